uart_rx_fifo: RTL and testbench

- 8N1 UART receiver, companion to the existing hello-world UART transmitter on the same iCE40 board.
- Samples the asynchronous uart_rx pin mid-bit and assembles bytes LSB-first.
- Validates start and stop bits and queues good bytes in a small FIFO with a valid/ready pop interface.
- Flags framing and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sfifo.sv | 56 +++++
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divide common to transmitter and receiver,
// and the receiver FSM state encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 104;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sfifo.sv
// Small synchronous FIFO with a registered head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_sfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     hwclk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic [PW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_next    = rd_ptr + PW'(do_pop);
  assign count_next = count + (PW+1)'(do_push) - (PW+1)'(do_pop);

  // NOTE: storage carries no reset; validity is defined solely by the pointers and count.
  always_ff @(posedge hwclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_next;
      count  <= count_next;
      // Head is the incoming byte only when nothing older remains after this cycle's pop.
      if (count_next != '0)
        dout <= (do_push && (rd_next == wr_ptr)) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, byte FIFO
// with valid/ready pop, and single-cycle framing/overrun error pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       hwclk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;

  rx_state_e state;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_d;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Idle-high reset values keep a reset release from looking like a start edge.
  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign push     = (state == STOP) && (cnt == '0) && rx_s;
  assign pop      = rx_ready && !fifo_empty;
  assign rx_valid = (fifo_count != '0);

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      bidx        <= '0;
      shreg       <= '0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (state != IDLE) cnt <= cnt - 1'b1;
      case (state)
        IDLE: if (rx_s_d && !rx_s) begin
          state <= START;
          cnt   <= CW'(CLKS_PER_BIT / 2 - 1);
          busy  <= 1'b1;
        end
        START: if (cnt == '0) begin
          if (!rx_s) begin
            state <= DATA;
            cnt   <= CW'(CLKS_PER_BIT - 1);
            bidx  <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: if (cnt == '0) begin
          shreg <= {rx_s, shreg[7:1]};
          cnt   <= CW'(CLKS_PER_BIT - 1);
          if (bidx == 3'd7) state <= STOP;
          else              bidx  <= bidx + 1'b1;
        end
        STOP: if (cnt == '0) begin
          if (rx_s) begin
            state       <= IDLE;
            busy        <= 1'b0;
            overrun_err <= fifo_full && !pop;
          end else begin
            state     <= BREAK;
            frame_err <= 1'b1;
          end
        end
        BREAK: if (rx_s) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  uart_rx_sfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .hwclk  (hwclk),
    .resetn (resetn),
    .push   (push),
    .din    (shreg),
    .pop    (pop),
    .dout   (rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// frames compared against a queue-based model of the receive path.
module tb_uart_rx_fifo;

  localparam int CPB   = 104;
  localparam int DEPTH = 4;

  logic       hwclk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 hwclk = ~hwclk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .hwclk       (hwclk),
    .resetn      (resetn),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  // Observer: counts error pulses and records every popped byte.
  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         back_pops = 0;
  int         rise_cyc = 0;
  logic       prev_pop = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] got [$];

  always @(posedge hwclk) cyc++;

  always @(negedge hwclk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun_err === 1'b1) ov_cnt++;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      got.push_back(rx_data);
      if (prev_pop) back_pops++;
      prev_pop = 1'b1;
    end else begin
      prev_pop = 1'b0;
    end
    prev_valid = rx_valid;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  int gi = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop;
    tick(CPB);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    rx_ready = 1'b1;
    while (rx_valid === 1'b1 && n < 4 * DEPTH) begin
      tick(1);
      n++;
    end
    rx_ready = 1'b0;
    check({tag, "_drained"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic expect_pop(input string tag, input logic [7:0] exp);
    if (gi < got.size()) begin
      check(tag, 32'(got[gi]), 32'(exp));
      gi++;
    end else begin
      check({tag, "_missing"}, 32'(got.size()), 32'(gi + 1));
    end
  endtask

  task automatic expect_no_more(input string tag);
    check(tag, 32'(got.size()), 32'(gi));
  endtask

  logic [7:0] hello [12] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0A};

  initial begin
    int fe0, ov0, bp0, start, lat, n, nbad;
    logic [7:0] b;
    logic good;
    logic [7:0] exp_q [$];

    tick(5);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    tick(20);

    // Single byte with latency window around the stop-bit sample.
    fe0 = fe_cnt; ov0 = ov_cnt;
    start = cyc;
    send_byte(8'h68, 1'b1);
    lat = rise_cyc - start;
    check("single_valid", 32'(rx_valid), 32'd1);
    check("single_data", 32'(rx_data), 32'h68);
    check("single_latency_in_window", 32'(lat >= 988 && lat <= 995), 32'd1);
    check("single_busy", 32'(busy), 32'd0);
    check("single_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("single_no_ov", 32'(ov_cnt - ov0), 32'd0);
    drain("single");
    expect_pop("single_pop", 8'h68);
    check("data_holds_when_empty", 32'(rx_data), 32'h68);

    // Short low glitch must not start a byte.
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    tick(20);
    check("glitch_busy_during", 32'(busy), 32'd1);
    tick(10);
    uart_rx = 1'b1;
    tick(100);
    check("glitch_busy_after", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(rx_valid), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);

    // Bad stop bit followed by a long break: one frame_err, then recovery.
    fe0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    tick(3000);
    check("break_one_fe", 32'(fe_cnt - fe0), 32'd1);
    check("break_busy", 32'(busy), 32'd1);
    check("break_no_valid", 32'(rx_valid), 32'd0);
    uart_rx = 1'b1;
    tick(50);
    check("break_exit_busy", 32'(busy), 32'd0);
    send_byte(8'hA5, 1'b1);
    check("break_still_one_fe", 32'(fe_cnt - fe0), 32'd1);
    drain("after_break");
    expect_pop("after_break_pop", 8'hA5);
    expect_no_more("after_break_only_one");

    // Overrun: fifth byte into a full FIFO is dropped.
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    check("ovr_none_yet", 32'(ov_cnt - ov0), 32'd0);
    send_byte(8'h05, 1'b1);
    check("ovr_one", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    drain("ovr");
    for (int i = 1; i <= 4; i++) expect_pop("ovr_pop", 8'(i));
    expect_no_more("ovr_fifth_dropped");

    // Back-to-back stream with the consumer always ready.
    fe0 = fe_cnt; ov0 = ov_cnt; bp0 = back_pops;
    rx_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_byte(hello[i], 1'b1);
    tick(20);
    rx_ready = 1'b0;
    for (int i = 0; i < 12; i++) expect_pop("stream_pop", hello[i]);
    expect_no_more("stream_count");
    check("stream_occupancy_le1", 32'(back_pops - bp0), 32'd0);
    check("stream_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("stream_no_ov", 32'(ov_cnt - ov0), 32'd0);

    // Reset during bit 4 of 0xFF; only the following byte may appear.
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(4 * CPB + 50);
    resetn = 1'b0;
    tick(2);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_data", 32'(rx_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fe", 32'(frame_err), 32'd0);
    check("midrst_ov", 32'(overrun_err), 32'd0);
    tick(10);
    resetn = 1'b1;
    tick(6 * CPB);
    send_byte(8'h3C, 1'b1);
    drain("midrst");
    expect_pop("midrst_pop", 8'h3C);
    expect_no_more("midrst_only_one");
    check("midrst_no_fe", 32'(fe_cnt - fe0), 32'd0);

    // Random frames, some with a bad stop bit, consumer ready.
    fe0 = fe_cnt; ov0 = ov_cnt; nbad = 0;
    exp_q.delete();
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_byte(b, good);
      if (good) exp_q.push_back(b);
      else begin
        nbad++;
        uart_rx = 1'b1;
        tick(CPB);
      end
    end
    tick(20);
    rx_ready = 1'b0;
    check("rand_fe_count", 32'(fe_cnt - fe0), 32'(nbad));
    check("rand_no_ov", 32'(ov_cnt - ov0), 32'd0);
    foreach (exp_q[i]) expect_pop("rand_pop", exp_q[i]);
    expect_no_more("rand_count");

    // Random burst into a stalled consumer: model keeps the first DEPTH bytes.
    ov0 = ov_cnt;
    exp_q.delete();
    n = $urandom_range(2, 7);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      if (i < DEPTH) exp_q.push_back(b);
    end
    check("burst_ov_count", 32'(ov_cnt - ov0), 32'((n > DEPTH) ? n - DEPTH : 0));
    drain("burst");
    foreach (exp_q[i]) expect_pop("burst_pop", exp_q[i]);
    expect_no_more("burst_count");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
